// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sram_port_arbiter
// Brief   : Two-port (MEM r/w, IF read-only) arbiter in front of one SRAM
//           controller command port. Optional macro ARB_ROUND_ROBIN_EN selects
//           round-robin tie breaking (default: fixed priority, MEM wins).
// Revision: 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_done,
    output logic              p0_stall,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_done,
    output logic              p1_stall,
    output logic              be_r_en,
    output logic              be_w_en,
    output logic [ADDR_W-1:0] be_addr,
    output logic [DATA_W-1:0] be_wdata,
    input  logic [DATA_W-1:0] be_rdata,
    input  logic              be_ready,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] c_timeout = TO_W'(TIMEOUT_CYCLES);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_grant;
    logic              r_we;
    logic              r_err;
    logic [TO_W-1:0]   r_watchdog;
    logic [TO_W-1:0]   w_wd_inc;
    logic              w_wd_expired;
    logic              w_grant_sel;
    logic              w_cmd_active;
    logic [DATA_W-1:0] w_rdata_cap;
`ifdef ARB_ROUND_ROBIN_EN
    logic              r_last_grant;
`endif

    // The counter reaches TIMEOUT_CYCLES at the end of the last allowed WAIT cycle.
    assign w_wd_inc     = r_watchdog + 1'b1;
    assign w_wd_expired = (TIMEOUT_CYCLES != 0) && (w_wd_inc == c_timeout);
    assign w_rdata_cap  = (be_ready && !r_we) ? be_rdata : '0;

    always_comb begin
        w_grant_sel = 1'b0;
        if (p0_req && p1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_grant_sel = ~r_last_grant;
`else
            w_grant_sel = 1'b0;
`endif
        end else if (p1_req) begin
            w_grant_sel = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (p0_req || p1_req) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (be_ready || w_wd_expired) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_watchdog   <= '0;
            be_addr      <= '0;
            be_wdata     <= '0;
            p0_rdata     <= '0;
            p1_rdata     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (p0_req || p1_req) begin
                        // Port 1 is read-only, so its command is always a read.
                        r_grant  <= w_grant_sel;
                        r_we     <= ~w_grant_sel & p0_we;
                        be_addr  <= w_grant_sel ? p1_addr : p0_addr;
                        be_wdata <= w_grant_sel ? '0 : p0_wdata;
                        r_err    <= 1'b0;
                    end
                end
                S_ISSUE: r_watchdog <= '0;
                S_WAIT: begin
                    r_watchdog <= w_wd_inc;
                    if (be_ready || w_wd_expired) begin
                        r_err <= ~be_ready;
                        if (r_grant) p1_rdata <= w_rdata_cap;
                        else         p0_rdata <= w_rdata_cap;
                    end
                end
`ifdef ARB_ROUND_ROBIN_EN
                S_DONE: r_last_grant <= r_grant;
`endif
                default: ;
            endcase
        end
    end

    assign w_cmd_active = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign be_r_en      = w_cmd_active & ~r_we;
    assign be_w_en      = w_cmd_active &  r_we;
    assign p0_done      = (r_state == S_DONE) & ~r_grant;
    assign p1_done      = (r_state == S_DONE) &  r_grant;
    assign err          = (r_state == S_DONE) &  r_err;

    // Gated by reset so the stalls drop the instant reset is asserted.
    assign p0_stall = rst & p0_req & ~p0_done;
    assign p1_stall = rst & p1_req & ~p1_done;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_port_arbiter
// Brief   : Directed plus randomized bench for sram_port_arbiter with a
//           transaction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req;
    logic [31:0] p0_addr, p0_wdata, p0_rdata, p1_addr, p1_rdata;
    logic        p0_done, p0_stall, p1_done, p1_stall;
    logic        be_r_en, be_w_en, be_ready, err;
    logic [31:0] be_addr, be_wdata, be_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending transaction per port, held read data, last grant.
    bit          pend[2];
    bit          tx_we[2];
    logic [31:0] tx_addr[2];
    logic [31:0] tx_wdata[2];
    logic [31:0] m_rd[2];
    int          m_last;

    sram_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T), .TO_W(3)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_done(p0_done), .p0_stall(p0_stall),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_rdata(p1_rdata),
        .p1_done(p1_done), .p1_stall(p1_stall),
        .be_r_en(be_r_en), .be_w_en(be_w_en), .be_addr(be_addr), .be_wdata(be_wdata),
        .be_rdata(be_rdata), .be_ready(be_ready), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL sim_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        if (pend[0] && pend[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
            return (m_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return pend[0] ? 0 : 1;
    endfunction

    task automatic drive_reqs();
        p0_req   = pend[0];
        p0_we    = tx_we[0];
        p0_addr  = tx_addr[0];
        p0_wdata = tx_wdata[0];
        p1_req   = pend[1];
        p1_addr  = tx_addr[1];
    endtask

    task automatic model_reset();
        pend[0] = 0; pend[1] = 0;
        m_rd[0] = '0; m_rd[1] = '0;
        m_last  = 1;
    endtask

    // Entered at posedge+1 of an IDLE cycle with requests driven; returns at
    // posedge+1 of the IDLE cycle following the done pulse.
    task automatic serve(input int lat, input logic [31:0] data, input bit scramble, input bit drop);
        int          w, o;
        bit          to;
        logic [31:0] exp_rd;
        w  = pick();
        o  = 1 - w;
        to = (lat >= T);
        exp_rd = (to || tx_we[w]) ? 32'h0 : data;

        @(negedge clk);
        chk("idle_cmd", {be_r_en, be_w_en}, 2'b00);
        chk("idle_stall", {p0_stall, p1_stall}, {pend[0], pend[1]});

        @(posedge clk); #1;
        if (scramble) begin
            if (w == 0) begin p0_addr = $urandom; p0_wdata = $urandom; p0_we = ~p0_we; end
            else        p1_addr = $urandom;
        end
        be_ready = 1'($urandom_range(0, 1));
        be_rdata = $urandom;
        @(negedge clk);
        chk("issue_en", {be_r_en, be_w_en}, tx_we[w] ? 2'b01 : 2'b10);
        chk("issue_addr", be_addr, tx_addr[w]);
        if (tx_we[w]) chk("issue_wdata", be_wdata, tx_wdata[w]);

        for (int k = 0; k < 64; k++) begin
            @(posedge clk); #1;
            be_ready = (k == lat);
            be_rdata = (k == lat) ? data : $urandom;
            if (drop && k == 0) begin
                if (w == 0) p0_req = 1'b0;
                else        p1_req = 1'b0;
            end
            @(negedge clk);
            chk("wait_en", {be_r_en, be_w_en}, tx_we[w] ? 2'b01 : 2'b10);
            chk("wait_addr", be_addr, tx_addr[w]);
            chk("wait_done", {p0_done, p1_done}, 2'b00);
            if (k == lat || k == T - 1) break;
        end

        @(posedge clk); #1;
        be_ready = 1'($urandom_range(0, 1));
        be_rdata = $urandom;
        @(negedge clk);
        chk("done_pulse", {p0_done, p1_done}, (w == 0) ? 2'b10 : 2'b01);
        chk("done_rdata", (w == 0) ? p0_rdata : p1_rdata, exp_rd);
        chk("held_rdata", (o == 0) ? p0_rdata : p1_rdata, m_rd[o]);
        chk("done_err", err, to);
        chk("done_cmd", {be_r_en, be_w_en}, 2'b00);
        chk("loser_stall", (o == 0) ? p0_stall : p1_stall, pend[o]);

        m_rd[w] = exp_rd;
        pend[w] = 0;
        m_last  = w;
        @(posedge clk); #1;
        be_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        be_ready = 1'b0; be_rdata = '0;
        tx_we[0] = 0; tx_we[1] = 0;
        tx_addr[0] = '0; tx_addr[1] = '0;
        tx_wdata[0] = '0; tx_wdata[1] = '0;
        model_reset();
        drive_reqs();
        p0_req = 1'b1; p1_req = 1'b1;

        // Reset state (requests high must not show up as stalls)
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {be_r_en, be_w_en, p0_done, p1_done, p0_stall, p1_stall, err}, 7'd0);
        chk("rst_be_addr", be_addr, 32'h0);
        chk("rst_be_wdata", be_wdata, 32'h0);
        chk("rst_rdata", {p0_rdata, p1_rdata}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive_reqs();

        // Stray be_ready in IDLE
        be_ready = 1'b1; be_rdata = 32'hDEADBEEF;
        repeat (3) begin
            @(negedge clk);
            chk("stray_ready", {p0_done, p1_done, be_r_en, be_w_en, err}, 5'd0);
            @(posedge clk); #1;
        end
        be_ready = 1'b0;

        // Single read on port 1
        pend[1] = 1; tx_addr[1] = 32'h40; drive_reqs();
        serve(0, 32'h12345678, 0, 0);
        drive_reqs();

        // Single write on port 0
        pend[0] = 1; tx_we[0] = 1; tx_addr[0] = 32'h100; tx_wdata[0] = 32'hA5A5A5A5;
        drive_reqs();
        serve(2, 32'h5555AAAA, 0, 0);
        drive_reqs();

        // Tie held over four transactions, starting from reset
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        tx_we[0] = 0; tx_addr[0] = 32'h200; tx_addr[1] = 32'h300;
        pend[0] = 1; pend[1] = 1;
        for (int i = 0; i < 4; i++) begin
            int w;
            drive_reqs();
            w = pick();
            serve(i, 32'h1000 + i, 0, 0);
            pend[w] = 1;
        end
        pend[0] = 0; pend[1] = 0;
        drive_reqs();

        // Timeout then a normal completion on the same port
        pend[1] = 1; tx_addr[1] = 32'h44; drive_reqs();
        serve(20, 32'hBADBAD00, 0, 0);
        drive_reqs();
        pend[1] = 1; tx_addr[1] = 32'h48; drive_reqs();
        serve(1, 32'hCAFEF00D, 0, 0);
        drive_reqs();

        // Asynchronous reset in the middle of WAIT
        pend[0] = 1; tx_we[0] = 1; tx_addr[0] = 32'h500; tx_wdata[0] = 32'h0BADF00D;
        drive_reqs();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("amid_rst_ctrl", {be_r_en, be_w_en, p0_done, p1_done, p0_stall, p1_stall, err}, 7'd0);
        chk("amid_rst_addr", be_addr, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        drive_reqs();
        pend[1] = 1; tx_addr[1] = 32'h80; drive_reqs();
        serve(0, 32'h87654321, 0, 0);
        drive_reqs();

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            if (!pend[0] && $urandom_range(0, 2) != 0) begin
                pend[0] = 1; tx_we[0] = 1'($urandom_range(0, 1));
                tx_addr[0] = $urandom; tx_wdata[0] = $urandom;
            end
            if (!pend[1] && $urandom_range(0, 2) != 0) begin
                pend[1] = 1; tx_we[1] = 0; tx_addr[1] = $urandom;
            end
            drive_reqs();
            be_ready = 1'($urandom_range(0, 1));
            be_rdata = $urandom;
            if (!pend[0] && !pend[1]) begin
                @(negedge clk);
                chk("rnd_idle", {p0_done, p1_done, be_r_en, be_w_en, err}, 5'd0);
                @(posedge clk); #1;
            end else begin
                serve($urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0));
                drive_reqs();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
